gray_counter_ud: RTL and testbench

//  Parametrised up/down Gray-code counter with enable, synchronous Gray-value load,

---
 rtl/gray_counter_ud.sv | 127 ++++++++++++
 tb/tb_gray_counter_ud.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/gray_counter_ud.sv
// -----------------------------------------------------------------------------
// gray_counter_ud
//   Up/down Gray-code counter with count enable, synchronous Gray-value load,
//   optional saturation at the ends of the range and a terminal-count pulse.
//   The binary state and its Gray image are written on the same clock edge
//   from the same next-state value, so gray == bin ^ (bin >> 1) on every cycle
//   and the Gray output moves by exactly one bit per enabled step.
//
// Parameters
//   WIDTH     counter width in bits (>= 2)
//   INIT_GRAY Gray value taken on reset
//   SATURATE  0: wrap at both ends, 1: hold at all-ones (up) / zero (down)
//
// Ports
//   clk        in   rising-edge clock
//   resetn     in   synchronous reset, active-low (beats load and en)
//   en         in   count enable, one step per cycle while high
//   up         in   direction, 1 = increment, 0 = decrement
//   load       in   synchronous load of load_gray (beats en)
//   load_gray  in   Gray-coded load value
//   gray       out  registered Gray count
//   bin        out  registered binary equivalent of gray
//   tc         out  registered one-cycle pulse on wrap / blocked step
//   at_max     out  bin is all-ones
//   at_min     out  bin is zero
// -----------------------------------------------------------------------------
module gray_counter_ud #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] INIT_GRAY = '0,
  parameter bit               SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin,
  output logic             tc,
  output logic             at_max,
  output logic             at_min
);

  // Gray to binary: each binary bit is the XOR of all Gray bits from the MSB
  // down to its own position.
  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = g;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  localparam logic [WIDTH-1:0] INIT_BIN = gray_to_bin(INIT_GRAY);
  localparam logic [WIDTH-1:0] MAX_BIN  = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic             tc_q;

  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gray_d;
  logic             tc_d;
  logic             top_q;
  logic             bottom_q;

  assign load_bin = gray_to_bin(load_gray);
  assign top_q    = (bin_q == MAX_BIN);
  assign bottom_q = (bin_q == '0);

  // Next-state: load beats en, otherwise step or hold. At either end of the
  // range the step either wraps or is blocked; both raise tc.
  always_comb begin
    bin_d = bin_q;
    tc_d  = 1'b0;
    if (load) begin
      bin_d = load_bin;
    end else if (en) begin
      if (up) begin
        if (top_q) begin
          tc_d  = 1'b1;
          bin_d = SATURATE ? bin_q : '0;
        end else begin
          bin_d = bin_q + ONE;
        end
      end else begin
        if (bottom_q) begin
          tc_d  = 1'b1;
          bin_d = SATURATE ? bin_q : MAX_BIN;
        end else begin
          bin_d = bin_q - ONE;
        end
      end
    end
  end

  // Gray register is fed from the binary next-state, not from bin_q, so both
  // registers update on the same edge with no added latency.
  assign gray_d = bin_to_gray(bin_d);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      bin_q  <= INIT_BIN;
      gray_q <= INIT_GRAY;
      tc_q   <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      tc_q   <= tc_d;
    end
  end

  assign gray   = gray_q;
  assign bin    = bin_q;
  assign tc     = tc_q;
  assign at_max = top_q;
  assign at_min = bottom_q;

endmodule

// File: tb/tb_gray_counter_ud.sv
// Bench for gray_counter_ud: three instances (4-bit wrapping with INIT_GRAY
// 0110, 4-bit saturating, 8-bit wrapping) share one input stream. Each has a
// reference model based on integer arithmetic; expected binary values for a
// Gray load are found by searching for the integer whose Gray image matches.
module tb_gray_counter_ud;

  logic       clk = 1'b0;
  logic       resetn, en, up, load;
  logic [3:0] lg4;
  logic [7:0] lg8;

  logic [3:0] gray_w, bin_w, gray_s, bin_s;
  logic [7:0] gray_8, bin_8;
  logic       tc_w, tc_s, tc_8, max_w, max_s, max_8, min_w, min_s, min_8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gray_counter_ud #(.WIDTH(4), .INIT_GRAY(4'b0110), .SATURATE(1'b0)) dut_w (
    .clk(clk), .resetn(resetn), .en(en), .up(up), .load(load), .load_gray(lg4),
    .gray(gray_w), .bin(bin_w), .tc(tc_w), .at_max(max_w), .at_min(min_w));

  gray_counter_ud #(.WIDTH(4), .INIT_GRAY(4'b0000), .SATURATE(1'b1)) dut_s (
    .clk(clk), .resetn(resetn), .en(en), .up(up), .load(load), .load_gray(lg4),
    .gray(gray_s), .bin(bin_s), .tc(tc_s), .at_max(max_s), .at_min(min_s));

  gray_counter_ud #(.WIDTH(8), .INIT_GRAY(8'h00), .SATURATE(1'b0)) dut_8 (
    .clk(clk), .resetn(resetn), .en(en), .up(up), .load(load), .load_gray(lg8),
    .gray(gray_8), .bin(bin_8), .tc(tc_8), .at_max(max_8), .at_min(min_8));

  // Reference state: counter value as a plain integer plus the tc pulse.
  int v_w, v_s, v_8;
  bit t_w, t_s, t_8;

  function automatic int gray_of(input int n);
    return n ^ (n >> 1);
  endfunction

  // Binary value of a Gray code by exhaustive search over the range.
  function automatic int bin_of_gray(input int g, input int w);
    for (int n = 0; n < (1 << w); n++) begin
      if (gray_of(n) == g) return n;
    end
    return -1;
  endfunction

  task automatic model(input int w, input bit sat, input int init_bin,
                       input bit r, input bit l, input bit e, input bit u,
                       input int lg, inout int v, output bit t);
    int top;
    top = (1 << w) - 1;
    t = 1'b0;
    if (!r) begin
      v = init_bin;
    end else if (l) begin
      v = bin_of_gray(lg, w);
    end else if (e) begin
      if (u) begin
        if (v == top) begin t = 1'b1; if (!sat) v = 0; end
        else v = v + 1;
      end else begin
        if (v == 0) begin t = 1'b1; if (!sat) v = top; end
        else v = v - 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_one(input string tag, input int v, input bit t, input int w,
                           input logic [31:0] g, input logic [31:0] b,
                           input logic tcv, input logic mx, input logic mn);
    chk({tag, ".gray"}, g, 32'(gray_of(v)));
    chk({tag, ".bin"}, b, 32'(v));
    chk({tag, ".tc"}, 32'(tcv), 32'(t));
    chk({tag, ".at_max"}, 32'(mx), 32'(v == (1 << w) - 1));
    chk({tag, ".at_min"}, 32'(mn), 32'(v == 0));
  endtask

  // One clock: drive inputs, step the models, sample 1 time unit after the edge.
  task automatic step(input string tag, input bit r, input bit l, input bit e,
                      input bit u, input logic [3:0] g4, input logic [7:0] g8);
    logic [3:0] pg_w;
    logic [7:0] pg_8;
    int         ov_w, ov_8;
    pg_w = gray_w; pg_8 = gray_8; ov_w = v_w; ov_8 = v_8;
    resetn = r; load = l; en = e; up = u; lg4 = g4; lg8 = g8;
    @(posedge clk);
    model(4, 1'b0, bin_of_gray(4'b0110, 4), r, l, e, u, int'(g4), v_w, t_w);
    model(4, 1'b1, 0, r, l, e, u, int'(g4), v_s, t_s);
    model(8, 1'b0, 0, r, l, e, u, int'(g8), v_8, t_8);
    #1;
    check_one({tag, ".w4"}, v_w, t_w, 4, 32'(gray_w), 32'(bin_w), tc_w, max_w, min_w);
    check_one({tag, ".s4"}, v_s, t_s, 4, 32'(gray_s), 32'(bin_s), tc_s, max_s, min_s);
    check_one({tag, ".w8"}, v_8, t_8, 8, 32'(gray_8), 32'(bin_8), tc_8, max_8, min_8);
    // Counting steps must flip exactly one Gray bit whenever the value moved.
    if (r && !l) begin
      chk({tag, ".w4.onebit"}, 32'($countones(gray_w ^ pg_w)), 32'(v_w != ov_w));
      chk({tag, ".w8.onebit"}, 32'($countones(gray_8 ^ pg_8)), 32'(v_8 != ov_8));
    end
    $display("step %s r=%0b l=%0b e=%0b u=%0b | w4 g=%b b=%0d tc=%0b | s4 b=%0d tc=%0b | w8 b=%0d tc=%0b",
             tag, r, l, e, u, gray_w, bin_w, tc_w, bin_s, tc_s, bin_8, tc_8);
  endtask

  initial begin
    resetn = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; lg4 = '0; lg8 = '0;
    v_w = 0; v_s = 0; v_8 = 0; t_w = 0; t_s = 0; t_8 = 0;

    // Reset value and hold with en=0.
    step("reset", 0, 0, 0, 0, 4'h0, 8'h00);
    step("reset", 0, 0, 0, 0, 4'h0, 8'h00);
    for (int i = 0; i < 10; i++) step("idle", 1, 0, 0, 0, 4'h0, 8'h00);

    // Count up from 0 for 17 steps: wrap on 4-bit, saturation on the other.
    step("load0", 1, 1, 0, 0, 4'h0, 8'h00);
    for (int i = 0; i < 17; i++) step("up17", 1, 0, 1, 1, 4'h0, 8'h00);

    // Down from 0 wraps to max, then alternate direction every cycle.
    step("load0", 1, 1, 0, 0, 4'h0, 8'h00);
    step("down", 1, 0, 1, 0, 4'h0, 8'h00);
    step("toggle", 1, 0, 1, 1, 4'h0, 8'h00);
    step("toggle", 1, 0, 1, 0, 4'h0, 8'h00);
    step("toggle", 1, 0, 1, 1, 4'h0, 8'h00);

    // Saturating end: load 15 (Gray 1000), push up 3 times, then step down.
    step("loadmax", 1, 1, 0, 0, 4'b1000, 8'h80);
    for (int i = 0; i < 3; i++) step("satup", 1, 0, 1, 1, 4'h0, 8'h00);
    step("satdown", 1, 0, 1, 0, 4'h0, 8'h00);

    // Load overrides en; next step up moves on from the loaded value.
    step("loaden", 1, 1, 1, 1, 4'b1101, 8'hA5);
    step("afterload", 1, 0, 1, 1, 4'h0, 8'h00);

    // Reset mid-count beats load and en.
    step("count", 1, 0, 1, 1, 4'h0, 8'h00);
    step("rstload", 0, 1, 1, 1, 4'b1111, 8'hFF);

    // 8-bit full wrap.
    step("load0", 1, 1, 0, 0, 4'h0, 8'h00);
    for (int i = 0; i < 257; i++) step("up257", 1, 0, 1, 1, 4'h0, 8'h00);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step("rand",
           $urandom_range(0, 99) >= 3,
           $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 80,
           1'($urandom),
           4'($urandom), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
